// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency memory between the
// instruction fetch port and the MEM-stage data port. One access is in flight
// at a time; data requests win over fetches. The arbiter returns registered
// read data with a one-cycle ready pulse, and it raises pipeline stalls until
// the access completes.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_pipe
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             acc_we_r;
    logic             d_req_s;
    logic             grant_d_s;
    logic             grant_i_s;
    logic             done_s;

    assign d_req_s    = d_read | d_write;
    // A port keeps the pipeline frozen until its ready pulse arrives.
    assign stall_pipe = d_req_s & ~d_ready;
    assign stall_if   = stall_pipe | (if_req & ~if_ready);

    // Next-state logic: grant in IDLE, then count down the memory latency in BUSY.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // A port whose ready pulse is high still holds its old request,
                // so that port is skipped in this cycle.
                if (d_req_s && !d_ready) begin
                    grant_d_s = 1'b1;
                    state_s   = BUSY_D;
                    cnt_s     = CNT_LOAD;
                end else if (if_req && !if_ready) begin
                    grant_i_s = 1'b1;
                    state_s   = BUSY_I;
                    cnt_s     = CNT_LOAD;
                end else begin
                    state_s   = IDLE;
                end
            end
            BUSY_D, BUSY_I: begin
                if (cnt_r == CNT_ZERO) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Memory command registers: launch one strobe cycle per granted access.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            acc_we_r  <= 1'b0;
        end else begin
            mem_en <= grant_d_s | grant_i_s;
            if (grant_d_s) begin
                // Read and write both high is treated as a write.
                mem_we    <= d_write;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                acc_we_r  <= d_write;
            end else if (grant_i_s) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                acc_we_r  <= 1'b0;
            end else begin
                mem_we    <= 1'b0;
            end
        end
    end

    // Completion registers: capture the returned word and pulse the matching ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            if_rdata <= 32'h0000_0000;
            d_rdata  <= 32'h0000_0000;
        end else begin
            if_ready <= done_s & (state_r == BUSY_I);
            d_ready  <= done_s & (state_r == BUSY_D);
            if (done_s && (state_r == BUSY_I)) begin
                if_rdata <= mem_rdata;
            end
            if (done_s && (state_r == BUSY_D) && !acc_we_r) begin
                d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a cycle-time model.
module tb_mem_port_arbiter;

    localparam int          LAT  = 2;
    localparam logic        Y    = 1'b1;
    localparam logic        N    = 1'b0;
    localparam logic [31:0] Z32  = 32'h0000_0000;
    localparam logic [31:0] JUNK = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_read, d_write;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_en, mem_we, stall_if, stall_pipe;

    logic [31:0] l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;
    logic        l1_if_ready, l1_d_ready, l1_mem_en, l1_mem_we, l1_stall_if, l1_stall_pipe;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.MEM_LAT(LAT), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_pipe(stall_pipe)
    );

    mem_port_arbiter #(.MEM_LAT(1), .CNT_W(4)) u_lat1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(l1_d_rdata), .d_ready(l1_d_ready),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(l1_stall_if), .stall_pipe(l1_stall_pipe)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [31:0] mrd;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ifr;
        logic        e_dr;
        logic [31:0] e_ifd;
        logic [31:0] e_dd;
        logic        e_sif;
        logic        e_sp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mrd,
                       input logic e_en, input logic e_we, input logic [31:0] e_addr,
                       input logic [31:0] e_wdata, input logic e_ifr, input logic e_dr,
                       input logic [31:0] e_ifd, input logic [31:0] e_dd,
                       input logic e_sif, input logic e_sp);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd; v.mrd = mrd;
        v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_ifr = e_ifr; v.e_dr = e_dr; v.e_ifd = e_ifd; v.e_dd = e_dd;
        v.e_sif = e_sif; v.e_sp = e_sp;
        tbl.push_back(v);
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = N; if_addr = Z32; d_read = N; d_write = N;
        d_addr = Z32; d_wdata = Z32; mem_rdata = JUNK;
    endtask

    // Reference model state, expressed as absolute cycle times of the single access.
    bit          m_busy, m_acc_d, m_acc_we;
    int          m_t;
    logic        m_en, m_we, m_if_ready, m_d_ready;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

    task automatic model_reset();
        m_busy = 0; m_acc_d = 0; m_acc_we = 0; m_t = 0;
        m_en = N; m_we = N; m_if_ready = N; m_d_ready = N;
        m_addr = Z32; m_wdata = Z32; m_if_rdata = Z32; m_d_rdata = Z32;
    endtask

    // Advance the model by the cycle c just checked; leaves the expectations for c+1.
    task automatic model_advance(input int c);
        logic n_en, n_ifr, n_dr;
        n_en = N; n_ifr = N; n_dr = N;
        if (rst) begin
            model_reset();
        end else begin
            if (!m_busy) begin
                if ((d_read | d_write) && !m_d_ready) begin
                    m_busy = 1; m_acc_d = 1; m_acc_we = d_write; m_t = c;
                    m_addr = d_addr; m_wdata = d_wdata; n_en = Y;
                end else if (if_req && !m_if_ready) begin
                    m_busy = 1; m_acc_d = 0; m_acc_we = 0; m_t = c;
                    m_addr = if_addr; n_en = Y;
                end
            end else if (c == m_t + 1 + LAT) begin
                m_busy = 0;
                if (m_acc_d) begin
                    n_dr = Y;
                    if (!m_acc_we) m_d_rdata = mem_rdata;
                end else begin
                    n_ifr = Y;
                    m_if_rdata = mem_rdata;
                end
            end
            m_en = n_en; m_we = n_en & m_acc_we; m_if_ready = n_ifr; m_d_ready = n_dr;
        end
    endtask

    bit          if_act, d_act, seen_ifr, seen_dr;
    logic        exp_sp, exp_sif;
    int unsigned kind;

    initial begin
        rst = Y;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst = N;

        // Directed table: idle, single fetch, data-over-fetch priority (MEM_LAT=2).
        for (int i = 0; i < 10; i++)
            row(N, Z32, N, N, Z32, Z32, JUNK, N, N, Z32, Z32, N, N, Z32, Z32, N, N);
        row(Y, 32'h40, N, N, Z32, Z32, JUNK, N, N, Z32, Z32, N, N, Z32, Z32, Y, N);
        row(Y, 32'h40, N, N, Z32, Z32, JUNK, Y, N, 32'h40, Z32, N, N, Z32, Z32, Y, N);
        row(Y, 32'h40, N, N, Z32, Z32, JUNK, N, N, Z32, Z32, N, N, Z32, Z32, Y, N);
        row(Y, 32'h40, N, N, Z32, Z32, 32'h8C22_0004, N, N, Z32, Z32, N, N, Z32, Z32, Y, N);
        row(Y, 32'h40, N, N, Z32, Z32, JUNK, N, N, Z32, Z32, Y, N, 32'h8C22_0004, Z32, N, N);
        row(N, Z32, N, N, Z32, Z32, JUNK, N, N, Z32, Z32, N, N, 32'h8C22_0004, Z32, N, N);
        row(Y, 32'h80, N, Y, 32'h100, 32'hDEAD_BEEF, JUNK, N, N, Z32, Z32, N, N, 32'h8C22_0004, Z32, Y, Y);
        row(Y, 32'h80, N, Y, 32'h100, 32'hDEAD_BEEF, JUNK, Y, Y, 32'h100, 32'hDEAD_BEEF, N, N, 32'h8C22_0004, Z32, Y, Y);
        row(Y, 32'h80, N, Y, 32'h100, 32'hDEAD_BEEF, JUNK, N, N, Z32, Z32, N, N, 32'h8C22_0004, Z32, Y, Y);
        row(Y, 32'h80, N, Y, 32'h100, 32'hDEAD_BEEF, 32'h5A5A_5A5A, N, N, Z32, Z32, N, N, 32'h8C22_0004, Z32, Y, Y);
        row(Y, 32'h80, N, Y, 32'h100, 32'hDEAD_BEEF, JUNK, N, N, Z32, Z32, N, Y, 32'h8C22_0004, Z32, Y, N);
        row(Y, 32'h80, N, N, Z32, Z32, JUNK, Y, N, 32'h80, Z32, N, N, 32'h8C22_0004, Z32, Y, N);
        row(Y, 32'h80, N, N, Z32, Z32, JUNK, N, N, Z32, Z32, N, N, 32'h8C22_0004, Z32, Y, N);
        row(Y, 32'h80, N, N, Z32, Z32, 32'h1234_5678, N, N, Z32, Z32, N, N, 32'h8C22_0004, Z32, Y, N);
        row(Y, 32'h80, N, N, Z32, Z32, JUNK, N, N, Z32, Z32, Y, N, 32'h1234_5678, Z32, N, N);
        row(N, Z32, N, N, Z32, Z32, JUNK, N, N, Z32, Z32, N, N, 32'h1234_5678, Z32, N, N);

        foreach (tbl[i]) begin
            step();
            if_req = tbl[i].ir; if_addr = tbl[i].ia; d_read = tbl[i].dr; d_write = tbl[i].dw;
            d_addr = tbl[i].da; d_wdata = tbl[i].dwd; mem_rdata = tbl[i].mrd;
            settle();
            chk($sformatf("row%0d_mem_en", i), {31'd0, mem_en}, {31'd0, tbl[i].e_en});
            chk($sformatf("row%0d_if_ready", i), {31'd0, if_ready}, {31'd0, tbl[i].e_ifr});
            chk($sformatf("row%0d_d_ready", i), {31'd0, d_ready}, {31'd0, tbl[i].e_dr});
            chk($sformatf("row%0d_if_rdata", i), if_rdata, tbl[i].e_ifd);
            chk($sformatf("row%0d_d_rdata", i), d_rdata, tbl[i].e_dd);
            chk($sformatf("row%0d_stall_if", i), {31'd0, stall_if}, {31'd0, tbl[i].e_sif});
            chk($sformatf("row%0d_stall_pipe", i), {31'd0, stall_pipe}, {31'd0, tbl[i].e_sp});
            if (tbl[i].e_en) begin
                chk($sformatf("row%0d_mem_we", i), {31'd0, mem_we}, {31'd0, tbl[i].e_we});
                chk($sformatf("row%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
                if (tbl[i].e_we) chk($sformatf("row%0d_mem_wdata", i), mem_wdata, tbl[i].e_wdata);
            end
        end

        // Held read through its ready cycle, then a new read: no re-grant on the ready cycle.
        step(); d_read = Y; d_addr = 32'h200; mem_rdata = JUNK; settle();
        step(); settle();
        chk("hold_first_en", {31'd0, mem_en}, 32'd1);
        chk("hold_first_addr", mem_addr, 32'h200);
        step(); settle();
        step(); mem_rdata = 32'hA1A1_A1A1; settle();
        step(); mem_rdata = JUNK; settle();
        chk("hold_first_ready", {31'd0, d_ready}, 32'd1);
        chk("hold_first_rdata", d_rdata, 32'hA1A1_A1A1);
        step(); d_addr = 32'h104; settle();
        chk("hold_no_regrant", {31'd0, mem_en}, 32'd0);
        chk("hold_ready_single", {31'd0, d_ready}, 32'd0);
        step(); settle();
        chk("hold_second_en", {31'd0, mem_en}, 32'd1);
        chk("hold_second_addr", mem_addr, 32'h104);
        step(); settle();
        chk("hold_rdata_kept", d_rdata, 32'hA1A1_A1A1);
        step(); mem_rdata = 32'hB2B2_B2B2; settle();
        chk("hold_rdata_before_done", d_rdata, 32'hA1A1_A1A1);
        step(); mem_rdata = JUNK; settle();
        chk("hold_second_ready", {31'd0, d_ready}, 32'd1);
        chk("hold_second_rdata", d_rdata, 32'hB2B2_B2B2);
        step(); d_read = N; d_addr = Z32; settle();
        chk("hold_second_ready_off", {31'd0, d_ready}, 32'd0);

        // Reset in the middle of a read aborts it without a ready pulse.
        step(); d_read = Y; d_addr = 32'h300; settle();
        step(); settle();
        chk("abort_en", {31'd0, mem_en}, 32'd1);
        step(); rst = Y; settle();
        step(); rst = N; d_read = N; d_addr = Z32; mem_rdata = 32'h5555_5555; settle();
        chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_mem_addr", mem_addr, Z32);
        chk("abort_mem_wdata", mem_wdata, Z32);
        chk("abort_if_ready", {31'd0, if_ready}, 32'd0);
        chk("abort_d_ready", {31'd0, d_ready}, 32'd0);
        chk("abort_if_rdata", if_rdata, Z32);
        chk("abort_d_rdata", d_rdata, Z32);
        chk("abort_stall_if", {31'd0, stall_if}, 32'd0);
        chk("abort_stall_pipe", {31'd0, stall_pipe}, 32'd0);
        step(); d_read = Y; d_addr = 32'h310; mem_rdata = JUNK; settle();
        chk("abort_no_ready", {31'd0, d_ready}, 32'd0);
        step(); settle();
        chk("after_abort_en", {31'd0, mem_en}, 32'd1);
        chk("after_abort_addr", mem_addr, 32'h310);
        step(); settle();
        step(); mem_rdata = 32'h6666_6666; settle();
        step(); mem_rdata = JUNK; settle();
        chk("after_abort_ready", {31'd0, d_ready}, 32'd1);
        chk("after_abort_rdata", d_rdata, 32'h6666_6666);
        step(); d_read = N; d_addr = Z32; settle();

        // MEM_LAT=1 instance: a load, then read+write together behaves as a write.
        step(); rst = Y; idle_inputs(); settle();
        step(); settle();
        step(); rst = N; d_read = Y; d_addr = 32'h20; settle();
        step(); settle();
        chk("lat1_read_en", {31'd0, l1_mem_en}, 32'd1);
        step(); mem_rdata = 32'h7777_7777; settle();
        step(); mem_rdata = JUNK; settle();
        chk("lat1_read_ready", {31'd0, l1_d_ready}, 32'd1);
        chk("lat1_read_rdata", l1_d_rdata, 32'h7777_7777);
        step(); d_write = Y; d_addr = 32'h24; d_wdata = 32'hCAFE_F00D; settle();
        chk("lat1_rw_ready_low", {31'd0, l1_d_ready}, 32'd0);
        step(); settle();
        chk("lat1_rw_en", {31'd0, l1_mem_en}, 32'd1);
        chk("lat1_rw_we", {31'd0, l1_mem_we}, 32'd1);
        chk("lat1_rw_addr", l1_mem_addr, 32'h24);
        chk("lat1_rw_wdata", l1_mem_wdata, 32'hCAFE_F00D);
        step(); mem_rdata = 32'h9999_9999; settle();
        step(); mem_rdata = JUNK; settle();
        chk("lat1_rw_ready", {31'd0, l1_d_ready}, 32'd1);
        chk("lat1_rw_rdata_kept", l1_d_rdata, 32'h7777_7777);
        step(); idle_inputs(); settle();
        chk("lat1_rw_ready_off", {31'd0, l1_d_ready}, 32'd0);

        // Randomized traffic on the MEM_LAT=2 instance against the model.
        step(); rst = Y; idle_inputs(); settle();
        model_reset();
        if_act = 0; d_act = 0; seen_ifr = 0; seen_dr = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            if (!if_act || seen_ifr) begin
                if_act = ($urandom_range(0, 2) == 0);
                if (if_act) if_addr = $urandom;
            end else if ($urandom_range(0, 39) == 0) begin
                if_act = 0;
            end
            if (!d_act || seen_dr) begin
                d_act = ($urandom_range(0, 2) == 0);
                if (d_act) begin
                    kind = $urandom_range(0, 2);
                    d_read = (kind != 1); d_write = (kind != 0);
                    d_addr = $urandom; d_wdata = $urandom;
                end
            end else if ($urandom_range(0, 39) == 0) begin
                d_act = 0;
            end
            if_req = if_act;
            if (!d_act) begin
                d_read = N; d_write = N;
            end
            mem_rdata = $urandom;
            settle();
            exp_sp  = (d_read | d_write) & ~m_d_ready;
            exp_sif = exp_sp | (if_req & ~m_if_ready);
            chk("rnd_mem_en", {31'd0, mem_en}, {31'd0, m_en});
            chk("rnd_if_ready", {31'd0, if_ready}, {31'd0, m_if_ready});
            chk("rnd_d_ready", {31'd0, d_ready}, {31'd0, m_d_ready});
            chk("rnd_if_rdata", if_rdata, m_if_rdata);
            chk("rnd_d_rdata", d_rdata, m_d_rdata);
            chk("rnd_stall_pipe", {31'd0, stall_pipe}, {31'd0, exp_sp});
            chk("rnd_stall_if", {31'd0, stall_if}, {31'd0, exp_sif});
            if (m_en) begin
                chk("rnd_mem_we", {31'd0, mem_we}, {31'd0, m_we});
                chk("rnd_mem_addr", mem_addr, m_addr);
                if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            seen_ifr = m_if_ready;
            seen_dr  = m_d_ready;
            model_advance(c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between instruction fetch (IF) and the data access of the MEM stage.
- The MEM-stage requests come from the EX/MEM control outputs (MemRead/MemWrite, ALU result as address, D2 as write data).
- Sequences each access, returns read data and generates stall signals.
- Those stall signals freeze the pipeline registers (their ld inputs) until the access completes.

Parameters:
- MEM_LAT, 2: cycles from the mem_en cycle to the cycle mem_rdata is valid (legal range 1..15).
- CNT_W, 4: width of the latency counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  instruction fetch request.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched instruction, registered.
- if_ready  out  1  one-cycle completion pulse for IF.
- d_read  in  1  data read request (MemRead).
- d_write  in  1  data write request (MemWrite).
- d_addr  in  32  data address (ALU result).
- d_wdata  in  32  write data (D2).
- d_rdata  out  32  load data, registered.
- d_ready  out  1  one-cycle completion pulse for the data port.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  write enable, valid with mem_en.
- mem_addr  out  32  memory address, valid with mem_en.
- mem_wdata  out  32  memory write data, valid with mem_en.
- mem_rdata  in  32  memory read data.
- stall_if  out  1  hold PC and IF/ID.
- stall_pipe  out  1  hold all pipeline registers.

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0. A reset during an access aborts it; the in-flight memory response is discarded and no ready pulse is generated.
- States: IDLE, BUSY_D, BUSY_I. A single access is outstanding at a time.
- Grant in IDLE:
  - Data (d_read|d_write) has strict priority over if_req.
  - A port whose ready pulse is high in the current cycle is not granted that cycle. This prevents re-granting a request still held during the advance edge.
- Issue, for a request accepted in IDLE at cycle T:
  - At the end of T: state <= BUSY_x; mem_en <= 1; mem_addr/mem_wdata/mem_we <= request values; counter <= MEM_LAT.
  - mem_en is high only in cycle T+1, then returns to 0.
- In BUSY, the counter decrements each cycle. mem_rdata is valid in cycle T+1+MEM_LAT, when the counter is 0.
- Completion, in the BUSY cycle with counter==0:
  - Capture mem_rdata into if_rdata or d_rdata. Writes leave d_rdata unchanged.
  - Pulse the matching ready for exactly one cycle (cycle T+2+MEM_LAT).
  - State <= IDLE.
- Latency is request to ready = MEM_LAT+2 cycles. Throughput is one access per MEM_LAT+2 cycles.
- rdata registers hold their value until the next completion on the same port.
- stall_pipe = (d_read|d_write) & ~d_ready (combinational).
- stall_if = stall_pipe | (if_req & ~if_ready).
- Requesters hold address, data and type stable until ready. A request dropped mid-access does not abort it: the access completes and its ready pulse is still generated.
- If d_read and d_write are both high, the access is a write (mem_we=1).
- Neither request asserted in IDLE: remain in IDLE, no mem_en.
- The counter never underflows; it is only reloaded on issue.

Test Plan:
1. Reset, then idle with no requests, MEM_LAT=2 -> all outputs 0 for 10 cycles; mem_en never asserted.
2. if_req=1, if_addr=0x40 at cycle 0, mem_rdata=0x8C220004 in cycle 3:
   - mem_en=1 with mem_addr=0x40 only in cycle 1.
   - if_ready=1 only in cycle 4, with if_rdata=0x8C220004.
   - stall_if high in cycles 0-3.
3. d_write=1, d_addr=0x100, d_wdata=0xDEADBEEF, plus if_req, at cycle 0:
   - Data is granted first: mem_we=1 in cycle 1; d_ready in cycle 4.
   - IF mem_en in cycle 5; if_ready in cycle 8.
   - stall_pipe high in cycles 0-3.
4. d_read held through cycle 4, then a new d_read at 0x104 in cycle 5 -> no re-grant in cycle 4; second mem_en in cycle 6; d_rdata updated only at completions.
5. rst in cycle 2 of a read -> cycle 3 all outputs 0; no ready pulse, even though mem_rdata is valid in cycle 3; a request in cycle 4 is issued normally.
6. d_read=d_write=1 with MEM_LAT=1 -> mem_we=1; d_ready in cycle 3; d_rdata unchanged.
